sha256_feed: RTL and testbench

Upstream feeder for the SHA-256 round core: accepts a message as a byte stream and assembles 512-bit blocks. Applies FIPS 180-4 padding and the 64-bit length field, and issues each block with the current chaining state to the core. Captures each core result as the next chaining state and emits the final digest.

---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_pad_fill.sv | 34 +++
 rtl/sha256_feed.sv | 139 +++++++++++++
 tb/tb_sha256_feed.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block feeder: chaining-state IVs,
// block/state typedefs and the feeder FSM encoding.
package sha256_pkg;

  typedef logic [63:0][7:0] block_t;
  typedef logic [7:0][31:0] state_t;

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_PAD2,
    S_ISSUE,
    S_GUARD,
    S_WAIT
  } feed_state_t;

  // Element [0] is H0, so the concatenations list H7 first.
  localparam state_t IV_SHA256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam state_t IV_SHA224 = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational padding builder: keeps bytes below p, places 0x80 at p and the
// big-endian bit length in bytes 56..63 when it fits (pad2 builds a length-only block).
module sha256_pad_fill
  import sha256_pkg::*;
(
  input  block_t      base,
  input  logic [5:0]  p,
  input  logic [63:0] bit_len,
  input  logic        pad2,
  output block_t      blk,
  output logic        last_blk
);

  // Message byte b lives at packed element b^3 (big-endian within each word).
  always_comb begin
    blk      = '0;
    last_blk = 1'b1;
    if (!pad2) begin
      for (logic [6:0] b = 7'd0; b < 7'd64; b = b + 7'd1) begin
        if (b[5:0] < p) begin
          blk[b[5:0] ^ 6'd3] = base[b[5:0] ^ 6'd3];
        end else if (b[5:0] == p) begin
          blk[b[5:0] ^ 6'd3] = 8'h80;
        end
      end
      last_blk = (p <= 6'd55);
    end
    if (last_blk) begin
      blk[59:56] = bit_len[63:32];
      blk[63:60] = bit_len[31:0];
    end
  end

endmodule

// File: rtl/sha256_feed.sv
// Byte-stream to 512-bit block feeder for the SHA-256 round core, with FIPS 180-4
// padding and chaining. Define SHA256_FEED_SHA224_EN for the SHA-224 IV and 7-word digest.
module sha256_feed
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       blk_valid,
  output block_t     blk_data,
  output state_t     blk_state,
  input  logic       cmp_valid,
  input  state_t     cmp_res,
  output logic       digest_valid,
  output state_t     digest
);

`ifdef SHA256_FEED_SHA224_EN
  localparam state_t IV          = IV_SHA224;
  localparam state_t DIGEST_MASK = {32'h0, {7{32'hffffffff}}};
`else
  localparam state_t IV          = IV_SHA256;
  localparam state_t DIGEST_MASK = {8{32'hffffffff}};
`endif

  feed_state_t       state;
  logic [5:0]        idx;
  logic [LEN_W-1:0]  bit_len;
  logic              msg_start;
  logic              pad_next;
  logic              pad2_next;
  logic              final_blk;
  logic [63:0]       len64;
  block_t            pad_blk;
  logic              pad_final;

  always_comb begin
    len64              = '0;
    len64[LEN_W-1:0]   = bit_len;
  end

  // idx already equals the pad position: last index + 1, or 0 after a full block.
  sha256_pad_fill u_pad_fill (
    .base     (blk_data),
    .p        (idx),
    .bit_len  (len64),
    .pad2     (state == S_PAD2),
    .blk      (pad_blk),
    .last_blk (pad_final)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FILL;
      idx          <= '0;
      bit_len      <= '0;
      msg_start    <= 1'b1;
      pad_next     <= 1'b0;
      pad2_next    <= 1'b0;
      final_blk    <= 1'b0;
      s_ready      <= 1'b0;
      blk_valid    <= 1'b0;
      digest_valid <= 1'b0;
      blk_data     <= '0;
      blk_state    <= IV;
      digest       <= '0;
    end else begin
      blk_valid    <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        S_FILL: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            blk_data[idx ^ 6'd3] <= s_data;
            idx                  <= idx + 6'd1;
            bit_len              <= bit_len + LEN_W'(8);
            if (msg_start) begin
              blk_state <= IV;
              msg_start <= 1'b0;
            end
            if (idx == 6'd63) begin
              state     <= S_ISSUE;
              blk_valid <= 1'b1;
              s_ready   <= 1'b0;
              pad_next  <= s_last;
              pad2_next <= 1'b0;
              final_blk <= 1'b0;
            end else if (s_last) begin
              state   <= S_PAD;
              s_ready <= 1'b0;
            end
          end
        end
        S_PAD, S_PAD2: begin
          blk_data  <= pad_blk;
          final_blk <= pad_final;
          pad2_next <= !pad_final;
          pad_next  <= 1'b0;
          blk_valid <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: state <= S_GUARD;
        // The core may still be showing out_valid from the previous block here.
        S_GUARD: state <= S_WAIT;
        S_WAIT: begin
          if (cmp_valid) begin
            blk_state <= cmp_res;
            if (final_blk) begin
              digest       <= cmp_res & DIGEST_MASK;
              digest_valid <= 1'b1;
              idx          <= '0;
              bit_len      <= '0;
              msg_start    <= 1'b1;
              final_blk    <= 1'b0;
              s_ready      <= 1'b1;
              state        <= S_FILL;
            end else if (pad2_next) begin
              state <= S_PAD2;
            end else if (pad_next) begin
              idx   <= '0;
              state <= S_PAD;
            end else begin
              idx     <= '0;
              s_ready <= 1'b1;
              state   <= S_FILL;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_feed.sv
// Self-checking bench for sha256_feed: behavioural round core plus a software SHA-256
// model over byte queues; honours SHA256_FEED_SHA224_EN for the expected IV and digest.
module tb_sha256_feed;
  import sha256_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

`ifdef SHA256_FEED_SHA224_EN
  localparam state_t TB_IV = IV_SHA224;
`else
  localparam state_t TB_IV = IV_SHA256;
`endif

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       blk_valid;
  block_t     blk_data;
  state_t     blk_state;
  logic       cmp_valid = 1'b0;
  state_t     cmp_res = '0;
  logic       digest_valid;
  state_t     digest;

  int checks = 0;
  int errors = 0;

  int           dv_count = 0;
  state_t       last_digest = '0;
  logic [511:0] blk_log[$];
  int           core_cnt = 0;
  int           hold = 0;
  state_t       core_res = '0;
  bit           inflight = 1'b0;
  int           sready_viol = 0;

  sha256_feed dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .blk_valid    (blk_valid),
    .blk_data     (blk_data),
    .blk_state    (blk_state),
    .cmp_valid    (cmp_valid),
    .cmp_res      (cmp_res),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Word j of the block is blk[32j +: 32], as the core sees it.
  function automatic state_t sha_compress(input state_t h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    state_t r;
    for (int j = 0; j < 16; j++) w[j] = blk[32*j +: 32];
    for (int j = 16; j < 64; j++) begin
      s0 = ror(w[j-15], 7) ^ ror(w[j-15], 18) ^ (w[j-15] >> 3);
      s1 = ror(w[j-2], 17) ^ ror(w[j-2], 19) ^ (w[j-2] >> 10);
      w[j] = w[j-16] + s0 + w[j-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int j = 0; j < 64; j++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[j] + w[j];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  // Whole-message reference: pad the byte list in software, then chain compressions.
  function automatic state_t sw_sha(input byte_q_t msg);
    byte_q_t      m;
    logic [63:0]  bl;
    state_t       h;
    logic [511:0] blk;
    m  = msg;
    bl = 64'(msg.size()) * 64'd8;
    m.push_back(8'h80);
    while (m.size() % 64 != 56) m.push_back(8'h00);
    for (int k = 7; k >= 0; k--) m.push_back(bl[8*k +: 8]);
    h = TB_IV;
    for (int base = 0; base < m.size(); base += 64) begin
      for (int j = 0; j < 16; j++)
        blk[32*j +: 32] = {m[base+4*j], m[base+4*j+1], m[base+4*j+2], m[base+4*j+3]};
      h = sha_compress(h, blk);
    end
`ifdef SHA256_FEED_SHA224_EN
    h[7] = 32'h0;
`endif
    return h;
  endfunction

  function automatic state_t mk_state(input logic [255:0] x);
    state_t s;
    for (int i = 0; i < 8; i++) s[i] = x[255-32*i -: 32];
    return s;
  endfunction

  function automatic byte_q_t str_bytes(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Round core model (about 65 cycles, out_valid lingers 4 cycles) and output monitor.
  always @(negedge clk) begin
    if (digest_valid) begin
      dv_count++;
      last_digest = digest;
    end
    if (inflight && s_ready) sready_viol++;
    if (hold > 0) hold--;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        hold     = 4;
        cmp_res  = core_res;
        inflight = 1'b0;
      end
    end
    cmp_valid = (hold > 0);
    if (blk_valid) begin
      core_res = sha_compress(blk_state, blk_data);
      core_cnt = 65;
      blk_log.push_back(blk_data);
      inflight = 1'b1;
    end
    if (rst) inflight = 1'b0;
  end

  task automatic send_msg(input byte_q_t msg, input bit gaps);
    int i = 0;
    int budget = 200 * msg.size() + 500;
    while (i < msg.size()) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = msg[i];
        s_last  = (i == msg.size() - 1);
      end
      if (s_valid && s_ready) i++;
      budget--;
      if (budget == 0) begin
        checks++; errors++;
        $display("[TB] FAIL send_timeout: accepted %0d bytes, required %0d", i, msg.size());
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_digest(input int start, output state_t d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      if (dv_count != start) begin
        ok = 1'b1;
        d  = last_digest;
        break;
      end
    end
  endtask

  task automatic run_msg(input string name, input byte_q_t msg, input bit gaps, output state_t got);
    int     dv0 = dv_count;
    int     nb0 = blk_log.size();
    int     exp_blocks = (msg.size() + 8) / 64 + 1;
    state_t exp = sw_sha(msg);
    bit     ok;
    send_msg(msg, gaps);
    wait_digest(dv0, got, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s digest_timeout: got no digest_valid, required one", name);
    end else if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s digest: got %h required %h", name, got, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (blk_log.size() - nb0 != exp_blocks) begin
      errors++;
      $display("[TB] FAIL %s blocks: got %0d required %0d", name, blk_log.size() - nb0, exp_blocks);
    end
    checks++;
    if (dv_count - dv0 != 1) begin
      errors++;
      $display("[TB] FAIL %s digest_pulses: got %0d required 1", name, dv_count - dv0);
    end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b required 0", s_ready); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_blk_valid: got %b required 0", blk_valid); end
    checks++;
    if (digest_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_digest_valid: got %b required 0", digest_valid); end
    checks++;
    if (digest !== '0) begin errors++; $display("[TB] FAIL reset_digest: got %h required 0", digest); end
    checks++;
    if (blk_data !== '0) begin errors++; $display("[TB] FAIL reset_blk_data: got %h required 0", blk_data); end
    checks++;
    if (blk_state !== TB_IV) begin errors++; $display("[TB] FAIL reset_blk_state: got %h required %h", blk_state, TB_IV); end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL reset_ready_rise: got s_ready low for 5 cycles, required high"); end
  endtask

  task automatic test_abc();
    state_t got;
`ifdef SHA256_FEED_SHA224_EN
    state_t want = mk_state(256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
`else
    state_t want = mk_state(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
`endif
    run_msg("abc", str_bytes("abc"), 1'b0, got);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL abc_known: got %h required %h", got, want); end
  endtask

  task automatic test_two_block();
    state_t got;
    byte_q_t m = str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
`ifdef SHA256_FEED_SHA224_EN
    state_t want = sw_sha(m);
`else
    state_t want = mk_state(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
`endif
    run_msg("msg56", m, 1'b1, got);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL msg56_known: got %h required %h", got, want); end
  endtask

  task automatic test_zero64();
    state_t       got;
    byte_q_t      m;
    logic [511:0] b1, b2;
    for (int i = 0; i < 64; i++) m.push_back(8'h00);
    run_msg("zero64", m, 1'b0, got);
    b1 = blk_log[blk_log.size() - 2];
    b2 = blk_log[blk_log.size() - 1];
    checks++;
    if (b1 !== '0) begin errors++; $display("[TB] FAIL zero64_block1: got %h required 0", b1); end
    checks++;
    if ({b2[24 +: 8], b2[488 +: 8], b2[480 +: 8]} !== 24'h800200) begin
      errors++;
      $display("[TB] FAIL zero64_block2_bytes: got %h required 800200", {b2[24 +: 8], b2[488 +: 8], b2[480 +: 8]});
    end
  endtask

  task automatic test_back_to_back();
    state_t  got;
    byte_q_t m;
    int      v0 = sready_viol;
    for (int k = 0; k < 2; k++) begin
      m = {};
      for (int i = 0; i < 150; i++) m.push_back(8'($urandom));
      run_msg("hold_valid", m, 1'b0, got);
    end
    checks++;
    if (sready_viol - v0 != 0) begin
      errors++;
      $display("[TB] FAIL ready_during_compress: got %0d cycles with s_ready high, required 0", sready_viol - v0);
    end
  endtask

  task automatic test_reset_wait();
    state_t  got;
    byte_q_t m;
    int      nb0 = blk_log.size();
    int      dv0;
    bit      issued = 1'b0;
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0);
    for (int c = 0; c < 100; c++) begin
      if (blk_log.size() != nb0) begin issued = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!issued) begin errors++; $display("[TB] FAIL rst_issue_timeout: got no blk_valid, required one"); end
    repeat (20) @(negedge clk);
    dv0 = dv_count;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (dv_count != dv0) begin errors++; $display("[TB] FAIL rst_stale_digest: got %0d pulses, required 0", dv_count - dv0); end
    run_msg("abc_after_rst", str_bytes("abc"), 1'b0, got);
  endtask

  task automatic test_random();
    int      lens [8] = '{1, 55, 56, 63, 64, 119, 120, 128};
    state_t  got;
    byte_q_t m;
    int      n;
    for (int t = 0; t < 14; t++) begin
      n = (t < 8) ? lens[t] : int'($urandom_range(1, 200));
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      run_msg($sformatf("rand_len%0d", n), m, 1'($urandom_range(0, 1)), got);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    $display("[TB] starting sha256_feed bench");
    test_reset();
    test_abc();
    test_two_block();
    test_zero64();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
